// File: rtl/riscv_pkg.sv
// Shared types for the instruction-fetch slice.
//   word_t / addr_t : 32-bit data word and byte address
//   fetch_state_e   : fetch FSM states (REQ, WAIT, HOLD, DROP)
//   INSTR_W         : instruction width in bits
//   word_align()    : clears the two byte-offset bits of an address
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [XLEN-1:0] addr_t;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  function automatic addr_t word_align(input addr_t a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// Single-entry skid buffer that parks a fetched instruction while ID is
// stalled.
//   clk, rst             : clock, synchronous active-high reset
//   load                 : capture load_pc / load_instr, entry becomes valid
//   clear                : drop the entry (wins over load)
//   load_pc, load_instr  : entry contents to capture
//   valid, pc, instr     : current entry
module if_skid_buf
  import riscv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [31:0]        load_pc,
  input  logic [INSTR_W-1:0] load_instr,
  output logic               valid,
  output logic [31:0]        pc,
  output logic [INSTR_W-1:0] instr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Payload carries no control meaning, so it is only written on load.
  always_ff @(posedge clk) begin
    if (load) begin
      pc    <= load_pc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding request to instruction memory,
// a registered instruction slot toward ID, and a one-entry skid buffer used
// when a response arrives while ID is stalled.
//   clk, rst                           : clock, synchronous active-high reset
//   stall_if                           : hold outputs, issue no new request
//   redirect_valid, redirect_pc        : taken branch/jump target (bits [1:0] ignored)
//   imem_req_valid/addr/ready          : request channel
//   imem_rsp_valid/data                : in-order response channel
//   if_valid, if_pc, if_instr          : registered instruction to ID
// Optional (macro IF_PERF_CNT_EN):
//   perf_fetch_cnt                     : instructions delivered to ID
//   perf_drop_cnt                      : responses discarded by redirect/DROP
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_if,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               imem_req_valid,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [31:0]        imem_rsp_data,
  output logic               if_valid,
  output logic [31:0]        if_pc,
  output logic [INSTR_W-1:0] if_instr
`ifdef IF_PERF_CNT_EN
  , output logic [31:0]      perf_fetch_cnt
  , output logic [31:0]      perf_drop_cnt
`endif
);

  fetch_state_e state, state_nxt;
  addr_t        pc, pc_nxt;
  addr_t        inflight_pc;

  logic         accept;
  logic         deliver_rsp;
  logic         deliver_skid;
  logic         skid_load;
  logic         skid_clear;
  logic         drop_evt;

  logic               skid_valid;
  logic [31:0]        skid_pc;
  logic [INSTR_W-1:0] skid_instr;

  // Request side: only REQ issues, and never while stalled or in reset.
  assign imem_req_valid = (state == REQ) && !stall_if && !rst;
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    deliver_rsp  = 1'b0;
    deliver_skid = 1'b0;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    drop_evt     = 1'b0;
    if (redirect_valid) begin
      pc_nxt = word_align(redirect_pc);
    end
    case (state)
      REQ: begin
        // A response here would be a protocol violation and is ignored.
        if (redirect_valid) begin
          state_nxt = accept ? DROP : REQ;
        end else if (accept) begin
          pc_nxt    = pc + 32'd4;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          if (imem_rsp_valid) begin
            drop_evt  = 1'b1;
            state_nxt = REQ;
          end else begin
            state_nxt = DROP;
          end
        end else if (imem_rsp_valid) begin
          if (stall_if) begin
            skid_load = 1'b1;
            state_nxt = HOLD;
          end else begin
            deliver_rsp = 1'b1;
            state_nxt   = REQ;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          skid_clear = 1'b1;
          drop_evt   = skid_valid;
          state_nxt  = REQ;
        end else if (!stall_if) begin
          deliver_skid = 1'b1;
          skid_clear   = 1'b1;
          state_nxt    = REQ;
        end
      end
      DROP: begin
        // The response belongs to a fetch made stale by a redirect.
        if (imem_rsp_valid) begin
          drop_evt  = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= REQ;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      inflight_pc <= pc;
    end
  end

  // Output slot: redirect flushes, delivery loads, stall holds, else bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_instr <= '0;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
    end else if (deliver_rsp) begin
      if_valid <= 1'b1;
      if_pc    <= inflight_pc;
      if_instr <= imem_rsp_data;
    end else if (deliver_skid) begin
      if_valid <= 1'b1;
      if_pc    <= skid_pc;
      if_instr <= skid_instr;
    end else if (!stall_if) begin
      if_valid <= 1'b0;
    end
  end

  if_skid_buf u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_pc    (inflight_pc),
    .load_instr (imem_rsp_data),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_drop_cnt  <= 32'h0;
    end else begin
      if (deliver_rsp || deliver_skid) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (drop_evt)                    perf_drop_cnt  <= perf_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Memory model: fixed latency, single outstanding request.
  int          lat = 1;
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  logic        rsp_inject;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_if       (stall_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt (perf_fetch_cnt)
    , .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ (a << 12);
  endfunction

  assign imem_rsp_valid = (mem_pend && mem_cnt == 1) || rsp_inject;
  assign imem_rsp_data  = mem_word(mem_addr);

  always @(posedge clk) begin
    if (rst) begin
      mem_pend <= 1'b0;
      mem_cnt  <= 0;
    end else begin
      if (mem_pend) begin
        mem_cnt <= mem_cnt - 1;
        if (mem_cnt == 1) mem_pend <= 1'b0;
      end
      if (imem_req_valid && imem_req_ready) begin
        mem_pend <= 1'b1;
        mem_cnt  <= lat;
        mem_addr <= imem_req_addr;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int latency);
    lat            = latency;
    rst            = 1'b1;
    stall_if       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    rsp_inject     = 1'b0;
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and straight-line fetch, 1-cycle latency
    apply_reset(1);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    rst = 1'b0; #1;
    check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0);
    step();
    check("wait_if_valid", {31'b0, if_valid}, 32'd0);
    check("wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
    step();
    check("i0_valid", {31'b0, if_valid}, 32'd1);
    check("i0_pc", if_pc, 32'h0);
    check("i0_instr", if_instr, 32'h0050_0093);
    check("i1_req_addr", imem_req_addr, 32'h4);
    step();
    check("bubble_valid", {31'b0, if_valid}, 32'd0);
    step();
    check("i1_valid", {31'b0, if_valid}, 32'd1);
    check("i1_pc", if_pc, 32'h4);
    step();
    step();
    check("i2_valid", {31'b0, if_valid}, 32'd1);
    check("i2_pc", if_pc, 32'h8);
    check("i2_instr", if_instr, 32'h0050_8093);

    // Stall while the response arrives -> HOLD, then release
    apply_reset(1);
    rst = 1'b0;
    step();
    stall_if = 1'b1;
    step();
    check("hold_if_valid", {31'b0, if_valid}, 32'd0);
    check("hold_req_valid", {31'b0, imem_req_valid}, 32'd0);
    step();
    step();
    check("hold3_if_valid", {31'b0, if_valid}, 32'd0);
    check("hold3_if_pc", if_pc, 32'h0);
    stall_if = 1'b0; #1;
    check("hold_rel_req_valid", {31'b0, imem_req_valid}, 32'd0);
    step();
    check("skid_valid", {31'b0, if_valid}, 32'd1);
    check("skid_pc", if_pc, 32'h0);
    check("skid_instr", if_instr, 32'h0050_0093);
    check("skid_next_addr", imem_req_addr, 32'h4);
    // Stalled in REQ with a spurious response: everything frozen
    stall_if = 1'b1;
    rsp_inject = 1'b1;
    step();
    check("frz_valid", {31'b0, if_valid}, 32'd1);
    check("frz_pc", if_pc, 32'h0);
    check("frz_instr", if_instr, 32'h0050_0093);
    rsp_inject = 1'b0;
    stall_if = 1'b0; #1;
    check("frz_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("frz_req_addr", imem_req_addr, 32'h4);
    step();
    check("frz_bubble", {31'b0, if_valid}, 32'd0);

    // Redirect in WAIT (2-cycle latency so the response is still pending)
    apply_reset(2);
    rst = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0; #1;
    check("rw_if_valid", {31'b0, if_valid}, 32'd0);
    check("rw_drop_req", {31'b0, imem_req_valid}, 32'd0);
    step();
    check("rw_stale_valid", {31'b0, if_valid}, 32'd0);
    check("rw_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("rw_req_addr", imem_req_addr, 32'h100);
`ifdef IF_PERF_CNT_EN
    check("rw_drop_cnt", perf_drop_cnt, 32'd1);
`endif
    step();
    step();
    step();
    check("rw_new_valid", {31'b0, if_valid}, 32'd1);
    check("rw_new_pc", if_pc, 32'h100);
    check("rw_new_instr", if_instr, 32'h0040_0093);

    // Redirect to unaligned target in the cycle the request is accepted
    apply_reset(1);
    rst = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203; #1;
    check("ra_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("ra_req_addr", imem_req_addr, 32'h0);
    step();
    redirect_valid = 1'b0; #1;
    check("ra_if_valid", {31'b0, if_valid}, 32'd0);
    check("ra_drop_req", {31'b0, imem_req_valid}, 32'd0);
    step();
    check("ra_stale_valid", {31'b0, if_valid}, 32'd0);
    check("ra_req_valid2", {31'b0, imem_req_valid}, 32'd1);
    check("ra_req_addr2", imem_req_addr, 32'h200);
`ifdef IF_PERF_CNT_EN
    check("ra_drop_cnt", perf_drop_cnt, 32'd1);
`endif
    step();
    step();
    check("ra_new_valid", {31'b0, if_valid}, 32'd1);
    check("ra_new_pc", if_pc, 32'h200);
    check("ra_new_instr", if_instr, 32'h0070_0093);
`ifdef IF_PERF_CNT_EN
    check("ra_fetch_cnt", perf_fetch_cnt, 32'd1);
`endif

    // Redirect while stalled in HOLD
    apply_reset(1);
    rst = 1'b0;
    step();
    stall_if = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    step();
    redirect_valid = 1'b0;
    stall_if       = 1'b0; #1;
    check("rh_if_valid", {31'b0, if_valid}, 32'd0);
    check("rh_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("rh_req_addr", imem_req_addr, 32'h300);
`ifdef IF_PERF_CNT_EN
    check("rh_drop_cnt", perf_drop_cnt, 32'd1);
`endif
    step();
    check("rh_no_skid", {31'b0, if_valid}, 32'd0);
    step();
    check("rh_new_valid", {31'b0, if_valid}, 32'd1);
    check("rh_new_pc", if_pc, 32'h300);
    check("rh_new_instr", if_instr, 32'h0060_0093);

    // Reset while a request is outstanding
    apply_reset(2);
    rst = 1'b0;
    step();
    rst = 1'b1; #1;
    check("rr_req_in_rst", {31'b0, imem_req_valid}, 32'd0);
    step();
    rst = 1'b0; #1;
    check("rr_if_valid", {31'b0, if_valid}, 32'd0);
    check("rr_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("rr_req_addr", imem_req_addr, 32'h0);
    step();
    step();
    step();
    check("rr_new_valid", {31'b0, if_valid}, 32'd1);
    check("rr_new_pc", if_pc, 32'h0);
    check("rr_new_instr", if_instr, 32'h0050_0093);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
